mil_txd: RTL and testbench

// MIL-STD-1553 word transmitter: Manchester-II encodes one 16-bit word with a 3-bit-time sync and odd parity.

---
 rtl/mil_txd.sv | 160 ++++++++++++++++
 tb/tb_mil_txd.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mil_txd.sv
// -----------------------------------------------------------------------------
// mil_txd : MIL-STD-1553 word transmitter.
// Sends one 16-bit word as Manchester-II, MSB first. The word is preceded by a
// 3-bit-time sync and followed by an odd parity bit. The outputs drive the
// differential pair toward the bus transceiver.
// If a new word is accepted on the last clock of the parity bit, the next sync
// starts on the following clock, so back-to-back words have no gap.
//
// Optional feature (macro MIL_TXD_PERR_EN): adds input tx_perr. It is latched
// when a word is accepted. When it is 1, the parity bit is inverted.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_start  in   send request, sampled while tx_ready=1
//   tx_cw     in   sync type: 1 = command/status, 0 = data
//   tx_dat    in   [15:0] word to send
//   tx_perr   in   (MIL_TXD_PERR_EN only) invert the parity bit
//   tx_ready  out  a word may be accepted this cycle
//   tx_busy   out  a word is on the bus
//   tx_done   out  pulse on the final clock of the parity bit
//   TXP/TXN   out  registered line drive
//
// state  | meaning
// IDLE   | bus quiet, TXP=TXN=0, waiting for tx_start
// SYNC   | 3 bit times: 1.5 bit one polarity, then 1.5 bit the other
// DATA   | 16 Manchester data bits, MSB first
// PARITY | one Manchester parity bit; a new start may be accepted on its last clock
// -----------------------------------------------------------------------------
module mil_txd #(
    parameter int Fclk  = 50000000,
    parameter int TXvel = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic        tx_cw,
    input  logic [15:0] tx_dat,
`ifdef MIL_TXD_PERR_EN
    input  logic        tx_perr,
`endif
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        TXP,
    output logic        TXN
);
    localparam int BIT  = Fclk / TXvel;
    localparam int HALF = BIT / 2;
    localparam int TW   = $clog2(BIT);
    localparam logic [TW-1:0] TACT_LAST = TW'(BIT - 1);
    localparam logic [TW-1:0] TACT_HALF = TW'(HALF);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] cb_tact, cb_tact_d;
    logic [3:0]    cb_bit, cb_bit_d;
    logic [15:0]   shift_q, shift_d;
    logic          par_q, par_d;
    logic          cw_q, cw_d;
    logic          txp_d;
    logic          ce_tact, accept, perr;

`ifdef MIL_TXD_PERR_EN
    assign perr = tx_perr;
`else
    assign perr = 1'b0;
`endif

    assign ce_tact  = (cb_tact == TACT_LAST);
    assign tx_done  = (state_q == PARITY) && ce_tact;
    assign tx_ready = (state_q == IDLE) || tx_done;
    assign tx_busy  = (state_q != IDLE);
    assign accept   = tx_start && tx_ready;

    always_comb begin
        state_d   = state_q;
        cb_tact_d = ce_tact ? '0 : cb_tact + 1'b1;
        cb_bit_d  = cb_bit;
        shift_d   = shift_q;
        par_d     = par_q;
        cw_d      = cw_q;
        case (state_q)
            IDLE: begin
                cb_tact_d = '0;
            end
            SYNC: begin
                if (ce_tact) begin
                    if (cb_bit == 4'd2) begin
                        state_d  = DATA;
                        cb_bit_d = '0;
                    end else begin
                        cb_bit_d = cb_bit + 1'b1;
                    end
                end
            end
            DATA: begin
                if (ce_tact) begin
                    shift_d = {shift_q[14:0], 1'b0};
                    if (cb_bit == 4'd15) begin
                        state_d  = PARITY;
                        cb_bit_d = '0;
                    end else begin
                        cb_bit_d = cb_bit + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (ce_tact) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Loading here overrides the PARITY -> IDLE exit, which makes back-to-back words gap-free.
        if (accept) begin
            state_d   = SYNC;
            cb_tact_d = '0;
            cb_bit_d  = '0;
            shift_d   = tx_dat;
            par_d     = ~^tx_dat ^ perr;
            cw_d      = tx_cw;
        end
    end

    // The line level is computed from the next-state values, so the registered
    // outputs show the first sync level on the clock right after accept.
    always_comb begin
        txp_d = 1'b0;
        case (state_d)
            // The first 1.5 bits of sync are all of bit time 0 plus the first half of bit time 1.
            SYNC:    txp_d = cw_d ~^ ((cb_bit_d == 4'd0) ||
                                      (cb_bit_d == 4'd1 && cb_tact_d < TACT_HALF));
            DATA:    txp_d = shift_d[15] ~^ (cb_tact_d < TACT_HALF);
            PARITY:  txp_d = par_d ~^ (cb_tact_d < TACT_HALF);
            default: txp_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cb_tact <= '0;
            cb_bit  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            cw_q    <= 1'b0;
            TXP     <= 1'b0;
            TXN     <= 1'b0;
        end else begin
            state_q <= state_d;
            cb_tact <= cb_tact_d;
            cb_bit  <= cb_bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cw_q    <= cw_d;
            TXP     <= (state_d != IDLE) &&  txp_d;
            TXN     <= (state_d != IDLE) && !txp_d;
        end
    end
endmodule

// File: tb/tb_mil_txd.sv
// -----------------------------------------------------------------------------
// tb_mil_txd : self-checking bench for mil_txd at the default rates
// (50 clocks per bit). It has a per-cycle reference model and a table of words.
// -----------------------------------------------------------------------------
module tb_mil_txd;
    localparam int BIT  = 50;
    localparam int HALF = 25;
    localparam int WORD = 20 * BIT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic        tx_cw = 1'b0;
    logic [15:0] tx_dat = 16'h0000;
    logic        tx_perr = 1'b0;
    logic        tx_ready, tx_busy, tx_done, TXP, TXN;

    mil_txd #(.Fclk(50000000), .TXvel(1000000)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_cw(tx_cw), .tx_dat(tx_dat),
`ifdef MIL_TXD_PERR_EN
        .tx_perr(tx_perr),
`endif
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .TXP(TXP), .TXN(TXN)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic txp; logic txn; logic busy; logic done; } samp_t;
    samp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic s_txp;
    int done_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Expected line activity of one whole word, built from the bit-time rules.
    task automatic push_word(input logic cw, input logic [15:0] dat, input logic perr);
        samp_t s;
        logic  b;
        int    bt, ph;
        for (int i = 0; i < WORD; i++) begin
            bt = i / BIT;
            ph = i % BIT;
            if (bt < 3) begin
                s.txp = cw ? (i < 3 * HALF) : !(i < 3 * HALF);
            end else begin
                if (bt < 19) b = dat[15 - (bt - 3)];
                else         b = (~^dat) ^ perr;
                s.txp = (ph < HALF) ? b : !b;
            end
            s.txn  = !s.txp;
            s.busy = 1'b1;
            s.done = (i == WORD - 1);
            exp_q.push_back(s);
        end
    endtask

    // One clock: check the outputs against the model, then drive the inputs for the next edge.
    task automatic run_cycle(input logic st, input logic cw, input logic [15:0] dat);
        samp_t e;
        logic  rdy;
        @(negedge clk);
        cyc++;
        e   = (exp_q.size() != 0) ? exp_q[0] : samp_t'(4'b0000);
        rdy = (exp_q.size() == 0) || exp_q[0].done;
        s_txp = TXP;
        if (tx_done) done_cyc.push_back(cyc);
        check("line", {27'd0, TXP, TXN, tx_busy, tx_done, tx_ready},
                      {27'd0, e.txp, e.txn, e.busy, e.done, rdy});
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        tx_start = st;
        tx_cw    = cw;
        tx_dat   = dat;
        if (st && rdy) push_word(cw, dat, tx_perr);
    endtask

    typedef struct { logic cw; logic [15:0] dat; logic sync_p; logic par; } vec_t;
    vec_t vt[5];

    initial begin
        vt[0] = '{1'b1, 16'hA5A5, 1'b1, 1'b1};
        vt[1] = '{1'b0, 16'h0001, 1'b0, 1'b0};
        vt[2] = '{1'b0, 16'hFFFF, 1'b0, 1'b1};
        vt[3] = '{1'b1, 16'h0000, 1'b1, 1'b1};
        vt[4] = '{1'b0, 16'h8000, 1'b0, 1'b0};

        // Reset state, then 2000 quiet clocks.
        #1;
        check("reset_state", {27'd0, TXP, TXN, tx_busy, tx_done, tx_ready}, 32'h1);
        run_cycle(0, 0, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) run_cycle(0, 0, 16'($urandom));

        // Table-driven single words. Inputs are scrambled after the accept.
        for (int v = 0; v < 5; v++) begin
            done_cyc.delete();
            run_cycle(1, vt[v].cw, vt[v].dat);
            for (int k = 1; k <= WORD; k++) begin
                run_cycle(0, 1'($urandom), 16'($urandom));
                if (k == 1)   check($sformatf("tbl%0d_sync", v), {31'd0, s_txp}, {31'd0, vt[v].sync_p});
                if (k == 951) check($sformatf("tbl%0d_par", v), {31'd0, s_txp}, {31'd0, vt[v].par});
            end
            check($sformatf("tbl%0d_done_cnt", v), done_cyc.size(), 1);
            for (int k = 0; k < 5; k++) run_cycle(0, 0, 16'h0);
        end

        // Start held high for three words, then released.
        done_cyc.delete();
        begin
            int acc = 0;
            int busy_low = 0;
            while (acc < 3) begin
                if (exp_q.size() == 0 || exp_q[0].done) acc++;
                run_cycle(1, 1'($urandom), 16'($urandom));
                if (cyc > 0 && acc > 1 && !tx_busy) busy_low++;
            end
            for (int k = 0; k < WORD + 5; k++) run_cycle(0, 0, 16'h0);
            check("b2b_busy_drop", busy_low, 0);
        end
        check("b2b_done_cnt", done_cyc.size(), 3);
        if (done_cyc.size() == 3) begin
            check("b2b_gap1", done_cyc[1] - done_cyc[0], WORD);
            check("b2b_gap2", done_cyc[2] - done_cyc[1], WORD);
        end

        // Reset pulse at clock 400 of a word. The word is abandoned, then a fresh word is sent.
        done_cyc.delete();
        run_cycle(1, 1, 16'h1234);
        for (int k = 1; k < 400; k++) run_cycle(0, 0, 16'h0);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_quiet", {29'd0, TXP, TXN, tx_busy}, 32'h0);
        exp_q.delete();
        run_cycle(0, 0, 16'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) run_cycle(0, 0, 16'h0);
        check("rst_mid_no_done", done_cyc.size(), 0);
        run_cycle(1, 0, 16'h5A3C);
        for (int k = 0; k < WORD + 5; k++) run_cycle(0, 0, 16'h0);
        check("rst_next_done", done_cyc.size(), 1);

        // Random traffic: sparse and dense starts, with inputs changing every clock.
        for (int k = 0; k < 8000; k++)
            run_cycle(($urandom_range(0, 99) < ((k < 4000) ? 2 : 60)), 1'($urandom), 16'($urandom));
        for (int k = 0; k < WORD + 5; k++) run_cycle(0, 0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
